// File: rtl/slice_permute_engine.sv
// Streams DEPTH 25-bit slices through a selectable step (pass, pi, inverse pi, chi).
// Optional macro SLICE_PERMUTE_IOTA_EN adds the rc port and folds rc[z] into lane (0,0) in chi mode.
module slice_permute_engine #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [24:0]      s_data,
`ifdef SLICE_PERMUTE_IOTA_EN
   input  logic [DEPTH-1:0] rc,
`endif
   output logic             m_valid,
   input  logic             m_ready,
   output logic [24:0]      m_data,
   output logic [IDX_W-1:0] m_idx
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic              mValid_q, mValid_d;
   logic [24:0]       mData_q, mData_d;
   logic [IDX_W-1:0]  mIdx_q, mIdx_d;
   logic [24:0]       stepOut;
   logic              xfer;

   function automatic logic [4:0] bitIdx(input int x, input int y);
      return 5'(5 * y + x);
   endfunction

   function automatic logic [24:0] piStep(input logic [24:0] d);
      logic [24:0] o;
      o = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            o[bitIdx(y, (2 * x + 3 * y) % 5)] = d[bitIdx(x, y)];
      return o;
   endfunction

   function automatic logic [24:0] invPiStep(input logic [24:0] d);
      logic [24:0] o;
      o = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            o[bitIdx((x + 3 * y) % 5, x)] = d[bitIdx(x, y)];
      return o;
   endfunction

   function automatic logic [24:0] chiStep(input logic [24:0] d);
      logic [24:0] o;
      o = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            o[bitIdx(x, y)] = d[bitIdx(x, y)] ^
                              (~d[bitIdx((x + 1) % 5, y)] & d[bitIdx((x + 2) % 5, y)]);
      return o;
   endfunction

   // Step function applied to the incoming slice using the mode latched at job start.
   always_comb begin
      stepOut = s_data;
      case (mode_q)
         2'd1:    stepOut = piStep(s_data);
         2'd2:    stepOut = invPiStep(s_data);
         2'd3:    stepOut = chiStep(s_data);
         default: stepOut = s_data;
      endcase
`ifdef SLICE_PERMUTE_IOTA_EN
      if (mode_q == 2'd3)
         stepOut[0] = stepOut[0] ^ rc[cnt_q];
`endif
   end

   assign s_ready = (state_q == RUN) && (!mValid_q || m_ready);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign m_valid = mValid_q;
   assign m_data  = mData_q;
   assign m_idx   = mIdx_q;

   // Next-state: a new transfer overrides a same-cycle consume so the output register stays full.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      mValid_d = mValid_q;
      mData_d  = mData_q;
      mIdx_d   = mIdx_q;
      xfer     = s_valid && s_ready;

      if (mValid_q && m_ready)
         mValid_d = 1'b0;

      if (xfer) begin
         mValid_d = 1'b1;
         mData_d  = stepOut;
         mIdx_d   = cnt_q;
         if (cnt_q == LAST)
            state_d = FLUSH;
         else
            cnt_d = cnt_q + IDX_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         FLUSH: begin
            if (mValid_q && m_ready)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mode_q   <= 2'd0;
         mValid_q <= 1'b0;
         mData_q  <= '0;
         mIdx_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         mValid_q <= mValid_d;
         mData_q  <= mData_d;
         mIdx_q   <= mIdx_d;
      end
   end

endmodule

// File: tb/tb_slice_permute_engine.sv
// Directed bench for slice_permute_engine: table of step-function vectors plus
// hand-written sequences for backpressure, start-while-busy and mid-job reset.
module tb_slice_permute_engine;

   localparam int DEPTH  = 64;
   localparam int IDX_W  = 6;
   localparam int BUDGET = 400;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic             busy;
   logic             done;
   logic             s_valid;
   logic             s_ready;
   logic [24:0]      s_data;
   logic             m_valid;
   logic             m_ready;
   logic [24:0]      m_data;
   logic [IDX_W-1:0] m_idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  md;
      logic [24:0] din;
      logic [24:0] dout;
   } vec_t;

   vec_t vecs[11];

   slice_permute_engine #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .busy    (busy),
      .done    (done),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_idx   (m_idx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Runs one full job; useIndex feeds slice z = z and expects z back, else every slice is din -> dout.
   task automatic applyStimulus(input string tag, input logic [1:0] md, input bit useIndex,
                                input logic [24:0] din, input logic [24:0] dout,
                                input int stallAt, input int stallLen, input int startAgainAt);
      int sent;
      int rcvd;
      int cyc;
      int doneCnt;
      int firstCyc;
      int lastCyc;
      bit inStall;
      logic [24:0] heldData;
      logic [IDX_W-1:0] heldIdx;
      logic [24:0] expData;
      sent = 0; rcvd = 0; cyc = 0; doneCnt = 0; firstCyc = -1; lastCyc = -1; inStall = 0;
      heldData = '0; heldIdx = '0;

      @(negedge clk);
      start = 1'b1; mode = md; m_ready = 1'b1; s_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0; mode = 2'd0;

      while (rcvd < DEPTH && cyc < BUDGET) begin
         @(negedge clk);
         s_valid = (sent < DEPTH);
         s_data  = useIndex ? 25'(sent) : din;
         m_ready = !(cyc >= stallAt && cyc < stallAt + stallLen);
         start   = (cyc == startAgainAt);
         mode    = start ? ~md : 2'd0;
         #1;
         if (done) doneCnt++;
         if (m_valid && !m_ready) begin
            if (!inStall) begin
               heldData = m_data; heldIdx = m_idx; inStall = 1;
            end else begin
               checkOutput({tag, ".holdData"}, 32'(m_data), 32'(heldData));
               checkOutput({tag, ".holdIdx"}, 32'(m_idx), 32'(heldIdx));
            end
            checkOutput({tag, ".stallReady"}, 32'(s_ready), 32'd0);
         end else begin
            inStall = 0;
         end
         if (m_valid && m_ready) begin
            expData = useIndex ? 25'(rcvd) : dout;
            checkOutput({tag, ".data"}, 32'(m_data), 32'(expData));
            checkOutput({tag, ".idx"}, 32'(m_idx), 32'(rcvd));
            if (firstCyc < 0) firstCyc = cyc;
            lastCyc = cyc;
            rcvd++;
         end
         if (s_valid && s_ready) sent++;
         cyc++;
      end
      s_valid = 1'b0; start = 1'b0;

      if (cyc >= BUDGET) begin
         checks++; errors++;
         $display("[TB] FAIL %s.timeout received=%0d required=%0d", tag, rcvd, DEPTH);
      end
      checkOutput({tag, ".doneEarly"}, 32'(doneCnt), 32'd0);
      if (stallLen == 0)
         checkOutput({tag, ".throughput"}, 32'(lastCyc - firstCyc), 32'(DEPTH - 1));
      @(negedge clk);
      checkOutput({tag, ".donePulse"}, 32'(done), 32'd1);
      @(negedge clk);
      checkOutput({tag, ".doneClear"}, 32'(done), 32'd0);
      checkOutput({tag, ".busyClear"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{2'd0, 25'h1234567, 25'h1234567};
      vecs[1]  = '{2'd1, 25'h0000002, 25'h0000400};
      vecs[2]  = '{2'd2, 25'h0000400, 25'h0000002};
      vecs[3]  = '{2'd1, 25'h0000020, 25'h0010000};
      vecs[4]  = '{2'd2, 25'h0010000, 25'h0000020};
      vecs[5]  = '{2'd1, 25'h0000001, 25'h0000001};
      vecs[6]  = '{2'd3, 25'h0000004, 25'h0000005};
      vecs[7]  = '{2'd3, 25'h1FFFFFF, 25'h1FFFFFF};
      vecs[8]  = '{2'd3, 25'h0000000, 25'h0000000};
      vecs[9]  = '{2'd3, 25'h0000040, 25'h0000240};
      vecs[10] = '{2'd3, 25'h0000003, 25'h000000B};

      rst = 1'b0; start = 1'b0; mode = 2'd0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.mValid", 32'(m_valid), 32'd0);
      checkOutput("reset.sReady", 32'(s_ready), 32'd0);
      checkOutput("reset.mData", 32'(m_data), 32'd0);
      checkOutput("reset.mIdx", 32'(m_idx), 32'd0);
      rst = 1'b1;

      applyStimulus("passIndex", 2'd0, 1'b1, '0, '0, -1, 0, -1);

      for (int i = 0; i < 11; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i].md, 1'b0, vecs[i].din, vecs[i].dout, -1, 0, -1);

      applyStimulus("stallPass", 2'd0, 1'b1, '0, '0, 30, 5, 10);
      applyStimulus("stallChi", 2'd3, 1'b0, 25'h0000004, 25'h0000005, 20, 5, 8);

      // Mid-job reset after slices 0..19 have been accepted.
      begin
         int sent;
         int guard;
         sent = 0; guard = 0;
         @(negedge clk);
         start = 1'b1; mode = 2'd0; m_ready = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         while (sent < 20 && guard < BUDGET) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 25'(sent);
            #1;
            if (s_valid && s_ready) sent++;
            guard++;
         end
         if (guard >= BUDGET) begin
            checks++; errors++;
            $display("[TB] FAIL midReset.timeout sent=%0d required=20", sent);
         end
         @(negedge clk);
         s_data = 25'd20; rst = 1'b0;
         @(negedge clk);
         checkOutput("midReset.mValid", 32'(m_valid), 32'd0);
         checkOutput("midReset.busy", 32'(busy), 32'd0);
         checkOutput("midReset.sReady", 32'(s_ready), 32'd0);
         checkOutput("midReset.mIdx", 32'(m_idx), 32'd0);
         checkOutput("midReset.mData", 32'(m_data), 32'd0);
         rst = 1'b1; s_valid = 1'b0;
         @(negedge clk);
         checkOutput("midReset.stayIdle", 32'(busy), 32'd0);
      end

      applyStimulus("afterReset", 2'd0, 1'b1, '0, '0, -1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
